// File: rtl/fproc_meas_resp.sv
// Measurement response block: answers core-controller requests with the latest per-channel measurement bit.
// Optional FPROC_TIMEOUT_EN macro adds a bounded wait in WAIT_MEAS and a sticky timeout output.
module fproc_meas_resp #(
  parameter int unsigned N_MEAS         = 8,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   fproc_id,
  input  logic                  fproc_enable,
  input  logic [N_MEAS-1:0]     meas,
  input  logic [N_MEAS-1:0]     meas_valid,
  output logic [DATA_WIDTH-1:0] fproc_data,
  output logic                  fproc_ready,
  output logic                  busy,
  output logic                  err_id
`ifdef FPROC_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);

  localparam int unsigned CH_W  = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;
`ifdef FPROC_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [1:0] {IDLE, WAIT_MEAS, RESP} state_t;

  state_t            state;
  logic [CH_W-1:0]   ch_q;
  logic              resp_err;
  logic [N_MEAS-1:0] stored;
  logic [N_MEAS-1:0] fresh;
`ifdef FPROC_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt;
`endif

  logic            req_ok;
  logic [CH_W-1:0] req_ch;

  // Request decode: upper ID bits only matter for the range check.
  always_comb begin
    req_ok = (32'(fproc_id) < 32'(N_MEAS));
    req_ch = CH_W'(fproc_id);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ch_q        <= '0;
      resp_err    <= 1'b0;
      stored      <= '0;
      fresh       <= '0;
      fproc_data  <= '0;
      fproc_ready <= 1'b0;
      busy        <= 1'b0;
      err_id      <= 1'b0;
`ifdef FPROC_TIMEOUT_EN
      cnt         <= '0;
      timeout     <= 1'b0;
`endif
    end else begin
      fproc_ready <= 1'b0;

      // Consume the answered channel; a strobe in the same cycle re-arms it below.
      if (state == RESP && !resp_err)
        fresh[ch_q] <= 1'b0;
      for (int k = 0; k < N_MEAS; k++) begin
        if (meas_valid[k]) begin
          fresh[k]  <= 1'b1;
          stored[k] <= meas[k];
        end
      end

      case (state)
        IDLE: begin
          if (fproc_enable) begin
            busy <= 1'b1;
            ch_q <= req_ch;
            if (!req_ok) begin
              state       <= RESP;
              fproc_ready <= 1'b1;
              fproc_data  <= '0;
              err_id      <= 1'b1;
              resp_err    <= 1'b1;
            end else if (fresh[req_ch] || meas_valid[req_ch]) begin
              state       <= RESP;
              fproc_ready <= 1'b1;
              fproc_data  <= DATA_WIDTH'(meas_valid[req_ch] ? meas[req_ch] : stored[req_ch]);
              resp_err    <= 1'b0;
            end else begin
              state    <= WAIT_MEAS;
              resp_err <= 1'b0;
`ifdef FPROC_TIMEOUT_EN
              cnt      <= '0;
`endif
            end
          end
        end
        WAIT_MEAS: begin
          if (meas_valid[ch_q]) begin
            state       <= RESP;
            fproc_ready <= 1'b1;
            fproc_data  <= DATA_WIDTH'(meas[ch_q]);
          end
`ifdef FPROC_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state       <= RESP;
            fproc_ready <= 1'b1;
            fproc_data  <= '1;
            timeout     <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
